countdown_bcd_timer: RTL and testbench
======================================

Name: countdown_bcd_timer

Overview:
Minutes:seconds BCD countdown timer (MM:SS, 99:59 max) for the digital-clock design. It is the down-counting counterpart of the clock's up-counting mod-10/mod-6 digit chain. It consumes the same 1 Hz enable pulse that drives the clock counters. It outputs four BCD digits to the display mux, plus status and a terminal pulse for the alarm/buzzer logic.

Parameters:
MIN_TENS_MAX, 9, highest legal minutes-tens digit; presets above it clamp to it.
DIGIT_W, 4, width of each BCD digit; fixed at 4 and not intended to be changed.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
ncr  in  1  asynchronous active-low reset; clears all state immediately.
tick  in  1  one-cycle 1 Hz enable; one pulse = one second.
load  in  1  load preset digits (pulse).
start  in  1  start/resume countdown (pulse).
stop  in  1  pause countdown (pulse).
pre_min_t  in  4  preset minutes tens.
pre_min_u  in  4  preset minutes units.
pre_sec_t  in  4  preset seconds tens.
pre_sec_u  in  4  preset seconds units.
min_t, min_u, sec_t, sec_u  out  4 each  current BCD digits.
running  out  1  high while in RUN.
done  out  1  high while in DONE.
zero_pulse  out  1  one-cycle pulse when the count reaches 00:00 during RUN.

Behaviour:
- Reset (ncr low, asynchronous):
  - all digits 0, state IDLE, running=0, done=0, zero_pulse=0.
  - Reset mid-run takes effect immediately; the countdown does not resume after release.
- States are IDLE, RUN, PAUSE, DONE. All outputs are registered.
- load:
  - Accepted in IDLE, PAUSE and DONE; ignored in RUN.
  - Next cycle: digits = clamped presets, state = IDLE.
  - Clamping: units digits > 9 become 9; sec tens > 5 becomes 5; min tens > MIN_TENS_MAX becomes MIN_TENS_MAX.
- start:
  - In IDLE or PAUSE with a nonzero count, go to RUN.
  - Ignored when the count is 00:00, in DONE, or in RUN.
- stop: in RUN, go to PAUSE; ignored otherwise.
- start and stop in the same cycle: stop wins. From IDLE/PAUSE the state is unchanged.
- load has priority over start and stop when accepted.
- Decrement: on tick while in RUN, subtract one second with a borrow chain. The decremented value is visible the cycle after the tick edge.
  - sec_u: 0 wraps to 9 and borrows.
  - sec_t: 0 wraps to 5 and borrows.
  - min_u: 0 wraps to 9 and borrows.
  - min_t decrements.
  - tick outside RUN has no effect.
- tick and stop in RUN in the same cycle: the decrement is applied and the state goes to PAUSE. If that decrement reaches zero, DONE takes precedence over PAUSE.
- Terminal count: a tick at 00:01 produces 00:00. In the same clock edge the state goes to DONE and zero_pulse is asserted for exactly one cycle.
- DONE holds 00:00 until load or ncr.
- Digits never leave the legal BCD range; there is no underflow below 00:00.

Optional Feature:
TIMER_AUTORELOAD_EN
- Defined:
  - A shadow register captures the clamped preset on every accepted load.
  - On terminal count, digits reload from the shadow, the state stays RUN, and zero_pulse still fires for one cycle.
  - DONE is reached only if the shadow value is 00:00; start is already rejected at zero, so that case is unreachable.
  - stop and load rules are unchanged.
- Undefined: no shadow register; the timer stops in DONE as described above.

Decomposition:
- Shared package (clock design constants):
  - state encodings ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE (2 bits);
  - BCD_UNITS_MAX = 4'd9 and SEC_TENS_MAX = 4'd5.
- One natural sub-module: bcd_down_digit.
  - Parameter WRAP.
  - Ports clk, ncr, load, load_val, dec_en (borrow in), q, borrow_out.
  - borrow_out is combinational: dec_en && q == 0.
  - Four instances are chained sec_u -> sec_t -> min_u -> min_t.
  - The top level holds the FSM, clamping, the shadow register and zero_pulse.

Test Plan:
- Reset: ncr low mid-RUN at 05:30 -> digits 00:00, running=0, done=0 immediately (asynchronous); start after release is ignored because the count is zero.
- Load 01:00, start, 1 tick -> 00:59, running=1; a further 59 ticks -> 00:00, done=1, zero_pulse high exactly one cycle.
- Borrow chain: load 10:00, start, tick -> 09:59; load 00:10, start, tick -> 00:09.
- Pause/priority:
  - 00:05 RUN, stop + tick in the same cycle -> 00:04, PAUSE.
  - Further ticks -> unchanged.
  - start + stop together -> still PAUSE.
  - start -> RUN.
- Clamp and ignore:
  - Preset F:C:7:A -> 9:9:5:9, i.e. 99:59.
  - load during RUN -> ignored, count continues.
  - load in DONE -> IDLE with the new value.
- TIMER_AUTORELOAD_EN: load 00:02, start, 2 ticks -> zero_pulse, digits back to 00:02, running=1; with the macro undefined -> DONE.

Source files
------------

// File: rtl/countdown_bcd_timer_pkg.sv
// Shared constants for the MM:SS countdown timer: FSM state encodings,
// BCD digit limits and a helper that clamps a preset digit.
package countdown_bcd_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [3:0] BCD_UNITS_MAX = 4'd9;
   localparam logic [3:0] SEC_TENS_MAX  = 4'd5;

   function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
      return (d > max) ? max : d;
   endfunction

endpackage

// File: rtl/countdown_bcd_timer_digit.sv
// One BCD down-counting digit: loads a value, decrements on dec_en and
// wraps from 0 to WRAP while raising a combinational borrow.
module bcd_down_digit #(
   parameter int unsigned WRAP    = 9,
   parameter int unsigned DIGIT_W = 4
) (
   input  logic               clk,
   input  logic               ncr,
   input  logic               load,
   input  logic [DIGIT_W-1:0] load_val,
   input  logic               dec_en,
   output logic [DIGIT_W-1:0] q,
   output logic               borrow_out
);

   always_ff @(posedge clk or negedge ncr) begin
      if (!ncr)
         q <= '0;
      else if (load)
         q <= load_val;
      else if (dec_en)
         q <= (q == '0) ? DIGIT_W'(WRAP) : q - DIGIT_W'(1);
   end

   assign borrow_out = dec_en && (q == '0);

endmodule

// File: rtl/countdown_bcd_timer.sv
// MM:SS BCD countdown timer driven by the 1 Hz tick. Optional feature macro:
// TIMER_AUTORELOAD_EN reloads the last preset on terminal count and keeps running.
module countdown_bcd_timer
   import countdown_bcd_timer_pkg::*;
#(
   parameter int unsigned MIN_TENS_MAX = 9,
   parameter int unsigned DIGIT_W      = 4
) (
   input  logic               clk,
   input  logic               ncr,
   input  logic               tick,
   input  logic               load,
   input  logic               start,
   input  logic               stop,
   input  logic [DIGIT_W-1:0] pre_min_t,
   input  logic [DIGIT_W-1:0] pre_min_u,
   input  logic [DIGIT_W-1:0] pre_sec_t,
   input  logic [DIGIT_W-1:0] pre_sec_u,
   output logic [DIGIT_W-1:0] min_t,
   output logic [DIGIT_W-1:0] min_u,
   output logic [DIGIT_W-1:0] sec_t,
   output logic [DIGIT_W-1:0] sec_u,
   output logic               running,
   output logic               done,
   output logic               zero_pulse
);

   state_t state, next_state;

   logic                 load_acc, dec, is_zero, is_one, terminal;
   logic                 digit_ld, reload_ok;
   logic [4*DIGIT_W-1:0] preset_c, ld_val;
   logic                 b_su, b_st, b_mu, b_mt;

   assign preset_c = {clamp_digit(pre_min_t, DIGIT_W'(MIN_TENS_MAX)),
                      clamp_digit(pre_min_u, BCD_UNITS_MAX),
                      clamp_digit(pre_sec_t, SEC_TENS_MAX),
                      clamp_digit(pre_sec_u, BCD_UNITS_MAX)};

   assign load_acc = load && (state != ST_RUN);
   assign dec      = tick && (state == ST_RUN);
   assign is_zero  = ({min_t, min_u, sec_t, sec_u} == '0);
   assign is_one   = ({min_t, min_u, sec_t} == '0) && (sec_u == DIGIT_W'(1));
   assign terminal = dec && is_one;

`ifdef TIMER_AUTORELOAD_EN
   logic [4*DIGIT_W-1:0] shadow;

   always_ff @(posedge clk or negedge ncr) begin
      if (!ncr)
         shadow <= '0;
      else if (load_acc)
         shadow <= preset_c;
   end

   // A zero shadow falls through to the plain decrement, which lands on 00:00 in DONE.
   assign reload_ok = (shadow != '0);
   assign digit_ld  = load_acc || (terminal && reload_ok);
   assign ld_val    = load_acc ? preset_c : shadow;
`else
   assign reload_ok = 1'b0;
   assign digit_ld  = load_acc;
   assign ld_val    = preset_c;
`endif

   bcd_down_digit #(.WRAP(9), .DIGIT_W(DIGIT_W)) u_sec_u (
      .clk(clk), .ncr(ncr), .load(digit_ld), .load_val(ld_val[DIGIT_W-1:0]),
      .dec_en(dec), .q(sec_u), .borrow_out(b_su));

   bcd_down_digit #(.WRAP(5), .DIGIT_W(DIGIT_W)) u_sec_t (
      .clk(clk), .ncr(ncr), .load(digit_ld), .load_val(ld_val[2*DIGIT_W-1:DIGIT_W]),
      .dec_en(b_su), .q(sec_t), .borrow_out(b_st));

   bcd_down_digit #(.WRAP(9), .DIGIT_W(DIGIT_W)) u_min_u (
      .clk(clk), .ncr(ncr), .load(digit_ld), .load_val(ld_val[3*DIGIT_W-1:2*DIGIT_W]),
      .dec_en(b_st), .q(min_u), .borrow_out(b_mu));

   bcd_down_digit #(.WRAP(MIN_TENS_MAX), .DIGIT_W(DIGIT_W)) u_min_t (
      .clk(clk), .ncr(ncr), .load(digit_ld), .load_val(ld_val[4*DIGIT_W-1:3*DIGIT_W]),
      .dec_en(b_mu), .q(min_t), .borrow_out(b_mt));

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE, ST_PAUSE: begin
            if (load)
               next_state = ST_IDLE;
            else if (start && !stop && !is_zero)
               next_state = ST_RUN;
         end
         ST_RUN: begin
            if (terminal)
               next_state = reload_ok ? ST_RUN : ST_DONE;
            else if (stop)
               next_state = ST_PAUSE;
         end
         ST_DONE: begin
            if (load)
               next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge ncr) begin
      if (!ncr) begin
         state      <= ST_IDLE;
         running    <= 1'b0;
         done       <= 1'b0;
         zero_pulse <= 1'b0;
      end else begin
         state      <= next_state;
         running    <= (next_state == ST_RUN);
         done       <= (next_state == ST_DONE);
         zero_pulse <= terminal;
      end
   end

endmodule

// File: tb/tb_countdown_bcd_timer.sv
// Scoreboard bench for countdown_bcd_timer: the driver queues expected
// results per cycle, the monitor compares them after each rising edge.
module tb_countdown_bcd_timer;

   logic       clk = 1'b0;
   logic       ncr;
   logic       tick, load, start, stop;
   logic [3:0] pre_min_t, pre_min_u, pre_sec_t, pre_sec_u;
   logic [3:0] min_t, min_u, sec_t, sec_u;
   logic       running, done, zero_pulse;

   countdown_bcd_timer #(.MIN_TENS_MAX(9), .DIGIT_W(4)) dut (
      .clk(clk), .ncr(ncr), .tick(tick), .load(load), .start(start), .stop(stop),
      .pre_min_t(pre_min_t), .pre_min_u(pre_min_u),
      .pre_sec_t(pre_sec_t), .pre_sec_u(pre_sec_u),
      .min_t(min_t), .min_u(min_u), .sec_t(sec_t), .sec_u(sec_u),
      .running(running), .done(done), .zero_pulse(zero_pulse));

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] dig;
      logic        run;
      logic        dn;
      logic        zp;
      int unsigned cyc;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc_n  = 0;
   int unsigned checks = 0;
   int unsigned errors = 0;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic compare(input string name, input logic [15:0] d, input logic r,
                          input logic dn, input logic zp);
      logic [15:0] got;
      got = {min_t, min_u, sec_t, sec_u};
      checks++;
      if (got !== d || running !== r || done !== dn || zero_pulse !== zp) begin
         errors++;
         $display("FAIL %s: got %h run=%b done=%b zp=%b, want %h run=%b done=%b zp=%b",
                  name, got, running, done, zero_pulse, d, r, dn, zp);
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      #2;
      while (sb.size() > 0 && sb[0].cyc <= cyc_n) begin
         e = sb.pop_front();
         compare(e.name, e.dig, e.run, e.dn, e.zp);
      end
   end

   task automatic drv(input logic t, input logic l, input logic s, input logic p);
      @(negedge clk);
      tick = t; load = l; start = s; stop = p;
   endtask

   task automatic expect_nx(input string n, input logic [15:0] d, input logic r,
                            input logic dn, input logic zp);
      exp_t e;
      e.name = n; e.dig = d; e.run = r; e.dn = dn; e.zp = zp; e.cyc = cyc_n + 1;
      sb.push_back(e);
   endtask

   task automatic setp(input logic [15:0] v);
      {pre_min_t, pre_min_u, pre_sec_t, pre_sec_u} = v;
   endtask

   initial begin
      int unsigned wait_cyc;
      logic [15:0] v;
      ncr = 1'b0;
      tick = 0; load = 0; start = 0; stop = 0;
      setp(16'h0000);
      repeat (2) @(negedge clk);
      #1 compare("reset_state", 16'h0000, 1'b0, 1'b0, 1'b0);
      @(negedge clk) ncr = 1'b1;

      drv(0, 0, 1, 0); expect_nx("start_at_zero", 16'h0000, 0, 0, 0);

      // 01:00 full countdown
      setp(16'h0100);
      drv(0, 1, 0, 0); expect_nx("load_0100", 16'h0100, 0, 0, 0);
      drv(0, 0, 1, 0); expect_nx("start_0100", 16'h0100, 1, 0, 0);
      drv(1, 0, 0, 0); expect_nx("tick_0059", 16'h0059, 1, 0, 0);
      for (int i = 58; i >= 1; i--) begin
         v = {8'h00, 4'(i / 10), 4'(i % 10)};
         drv(1, 0, 0, 0); expect_nx("count_down", v, 1, 0, 0);
      end
`ifdef TIMER_AUTORELOAD_EN
      drv(1, 0, 0, 0); expect_nx("terminal_reload", 16'h0100, 1, 0, 1);
      drv(0, 0, 0, 0); expect_nx("zp_one_cycle", 16'h0100, 1, 0, 0);
      drv(0, 0, 0, 1); expect_nx("stop_after_reload", 16'h0100, 0, 0, 0);
`else
      drv(1, 0, 0, 0); expect_nx("terminal_done", 16'h0000, 0, 1, 1);
      drv(0, 0, 0, 0); expect_nx("zp_one_cycle", 16'h0000, 0, 1, 0);
      drv(0, 0, 0, 1); expect_nx("stop_in_done", 16'h0000, 0, 1, 0);
`endif

      // borrow chain
      setp(16'h1000);
      drv(0, 1, 0, 0); expect_nx("load_1000", 16'h1000, 0, 0, 0);
      drv(0, 0, 1, 0); expect_nx("start_1000", 16'h1000, 1, 0, 0);
      drv(1, 0, 0, 0); expect_nx("borrow_0959", 16'h0959, 1, 0, 0);
      drv(0, 0, 0, 1); expect_nx("stop_0959", 16'h0959, 0, 0, 0);
      setp(16'h0010);
      drv(0, 1, 0, 0); expect_nx("load_0010", 16'h0010, 0, 0, 0);
      drv(0, 0, 1, 0); expect_nx("start_0010", 16'h0010, 1, 0, 0);
      drv(1, 0, 0, 0); expect_nx("borrow_0009", 16'h0009, 1, 0, 0);
      drv(0, 0, 0, 1); expect_nx("stop_0009", 16'h0009, 0, 0, 0);

      // pause and priority
      setp(16'h0005);
      drv(0, 1, 0, 0); expect_nx("load_0005", 16'h0005, 0, 0, 0);
      drv(0, 0, 1, 0); expect_nx("start_0005", 16'h0005, 1, 0, 0);
      drv(1, 0, 0, 1); expect_nx("stop_tick", 16'h0004, 0, 0, 0);
      drv(1, 0, 0, 0); expect_nx("tick_in_pause", 16'h0004, 0, 0, 0);
      drv(0, 0, 1, 1); expect_nx("start_stop_pause", 16'h0004, 0, 0, 0);
      drv(0, 0, 1, 0); expect_nx("resume", 16'h0004, 1, 0, 0);
      setp(16'h0707);
      drv(1, 1, 0, 0); expect_nx("load_in_run", 16'h0003, 1, 0, 0);
      drv(1, 0, 0, 0); expect_nx("tick_0002", 16'h0002, 1, 0, 0);
      drv(1, 0, 0, 0); expect_nx("tick_0001", 16'h0001, 1, 0, 0);
`ifdef TIMER_AUTORELOAD_EN
      drv(1, 0, 0, 0); expect_nx("reload_0005", 16'h0005, 1, 0, 1);
      drv(0, 0, 0, 1); expect_nx("stop_0005", 16'h0005, 0, 0, 0);
`else
      drv(1, 0, 0, 1); expect_nx("done_over_pause", 16'h0000, 0, 1, 1);
      drv(0, 0, 1, 0); expect_nx("start_in_done", 16'h0000, 0, 1, 0);
`endif

      // clamp
      setp(16'hFC7A);
      drv(0, 1, 0, 0); expect_nx("clamp_9959", 16'h9959, 0, 0, 0);
      drv(0, 0, 1, 0); expect_nx("start_9959", 16'h9959, 1, 0, 0);
      drv(1, 0, 0, 0); expect_nx("tick_9958", 16'h9958, 1, 0, 0);
      drv(0, 0, 0, 1); expect_nx("stop_9958", 16'h9958, 0, 0, 0);

      // short run to terminal
      setp(16'h0002);
      drv(0, 1, 0, 0); expect_nx("load_0002", 16'h0002, 0, 0, 0);
      drv(0, 0, 1, 0); expect_nx("start_0002", 16'h0002, 1, 0, 0);
      drv(1, 0, 0, 0); expect_nx("tick_0001b", 16'h0001, 1, 0, 0);
`ifdef TIMER_AUTORELOAD_EN
      drv(1, 0, 0, 0); expect_nx("reload_0002", 16'h0002, 1, 0, 1);
      drv(0, 0, 0, 1); expect_nx("stop_0002", 16'h0002, 0, 0, 0);
`else
      drv(1, 0, 0, 0); expect_nx("done_0000", 16'h0000, 0, 1, 1);
      drv(0, 0, 0, 0); expect_nx("done_hold", 16'h0000, 0, 1, 0);
`endif

      // asynchronous reset mid-run
      setp(16'h0530);
      drv(0, 1, 0, 0); expect_nx("load_0530", 16'h0530, 0, 0, 0);
      drv(0, 0, 1, 0); expect_nx("start_0530", 16'h0530, 1, 0, 0);
      drv(1, 0, 0, 0); expect_nx("tick_0529", 16'h0529, 1, 0, 0);
      drv(0, 0, 0, 0); expect_nx("run_0529", 16'h0529, 1, 0, 0);
      @(negedge clk);
      #2 ncr = 1'b0;
      #1 compare("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
      @(negedge clk) ncr = 1'b1;
      drv(0, 0, 1, 0); expect_nx("start_after_reset", 16'h0000, 0, 0, 0);
      drv(1, 0, 0, 0); expect_nx("tick_after_reset", 16'h0000, 0, 0, 0);
      drv(0, 0, 0, 0);

      wait_cyc = 0;
      while (sb.size() > 0 && wait_cyc < 20) begin
         @(negedge clk);
         wait_cyc++;
      end
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
